// File: rtl/dcache_burst_pkg.sv
// Shared types for the data-cache burst adapter.
// Holds the burst FSM state encoding used by dcache_burst_adapter.
// No logic; types only.
package dcache_burst_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_BURST  = 2'd1,
    WRITE_BURST = 2'd2,
    DONE        = 2'd3
  } burst_state_t;

endpackage

// File: rtl/dcache_burst_adapter.sv
// Purpose: splits cache-line refill/writeback requests into BURST_COUNT memory beats.
// Latency: request accepted at cycle 0, memory request from cycle 1, resp_o one cycle after the last beat ack.
// Backpressure: resp_i low stalls the current beat indefinitely; cache requests are ignored outside IDLE.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   line_i/line_o     writeback line from cache / refill line to cache
//   address_i         cache line address (offset bits dropped when latched)
//   read_i/write_i    cache refill / writeback request (write wins when both set)
//   resp_o            one-cycle completion pulse to cache
//   burst_i/burst_o   memory read beat / memory write beat
//   address_o         line-aligned memory address
//   read_o/write_o    memory read / write request, high for the whole burst
//   resp_i            per-beat memory acknowledge
module dcache_burst_adapter
  import dcache_burst_pkg::*;
#(
  parameter int CACHELINE_BIT_WIDTH = 256,
  parameter int BURST_WIDTH         = 64,
  parameter int ADDR_WIDTH          = 32,
  parameter int OFFSET_BITS         = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CACHELINE_BIT_WIDTH-1:0] line_i,
  output logic [CACHELINE_BIT_WIDTH-1:0] line_o,
  input  logic [ADDR_WIDTH-1:0]          address_i,
  input  logic                           read_i,
  input  logic                           write_i,
  output logic                           resp_o,
  input  logic [BURST_WIDTH-1:0]         burst_i,
  output logic [BURST_WIDTH-1:0]         burst_o,
  output logic [ADDR_WIDTH-1:0]          address_o,
  output logic                           read_o,
  output logic                           write_o,
  input  logic                           resp_i
);

  localparam int BURST_COUNT = CACHELINE_BIT_WIDTH / BURST_WIDTH;
  localparam int CNT_W       = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);

  // Line viewed as an array of beats so the counter indexes a beat directly.
  typedef logic [BURST_COUNT-1:0][BURST_WIDTH-1:0] beats_t;

  burst_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  beats_t                wline_q, wline_d;
  beats_t                rline_q, rline_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] addr_aligned;

  // Offset bits are discarded: memory always sees a line-aligned address.
  assign addr_aligned = {address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  logic unused_offset_bits;
  assign unused_offset_bits = ^address_i[OFFSET_BITS-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wline_d = wline_q;
    rline_d = rline_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          wline_d = line_i;
          addr_d  = addr_aligned;
          state_d = WRITE_BURST;
        end else if (read_i) begin
          addr_d  = addr_aligned;
          state_d = READ_BURST;
        end
      end
      READ_BURST: begin
        if (resp_i) begin
          rline_d[cnt_q] = burst_i;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE_BURST: begin
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wline_q <= '0;
      rline_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      addr_q  <= addr_d;
    end
  end

  assign line_o    = rline_q;
  assign address_o = addr_q;
  assign read_o    = (state_q == READ_BURST);
  assign write_o   = (state_q == WRITE_BURST);
  assign resp_o    = (state_q == DONE);
  // Driven only during a writeback so memory never sees stale line data.
  assign burst_o   = (state_q == WRITE_BURST) ? wline_q[cnt_q] : '0;

endmodule

// File: tb/tb_dcache_burst_adapter.sv
// Purpose: randomized scoreboard bench for dcache_burst_adapter.
// Latency: expects memory request one cycle after acceptance, resp_o one cycle after the last ack.
// Backpressure: drives random resp_i stalls and junk requests while the adapter is busy.
module tb_dcache_burst_adapter;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] line_i, line_o;
  logic [AW-1:0] address_i, address_o;
  logic          read_i, write_i, resp_o;
  logic [BW-1:0] burst_i, burst_o;
  logic          read_o, write_o, resp_i;

  always #5 clk = ~clk;

  dcache_burst_adapter #(
    .CACHELINE_BIT_WIDTH(LW),
    .BURST_WIDTH        (BW),
    .ADDR_WIDTH         (AW),
    .OFFSET_BITS        (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  // One expected transaction: kind, aligned address, refill line, busy cycles.
  typedef struct {
    bit            is_rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
    int            busy;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] wq[$];
  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] model_line = '0;
  int            busy_cnt = 0;
  bit            prev_resp = 1'b0;
  int            fixed_pat[$];
  exp_t          mon_e;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: samples on the falling edge, pops expectations when the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wq.delete();
      model_line = '0;
      busy_cnt   = 0;
      prev_resp  = 1'b0;
    end else begin
      if (read_o && write_o) fail("read_o_and_write_o");
      if (read_o || write_o) begin
        busy_cnt++;
        if (exp_q.size() == 0) fail("unexpected_burst");
        else begin
          chk("address_o", LW'(address_o), LW'(exp_q[0].addr));
          chk("read_o_kind", LW'(read_o), LW'(exp_q[0].is_rd));
        end
      end
      if (write_o && resp_i) begin
        if (wq.size() == 0) fail("extra_write_beat");
        else chk("burst_o", LW'(burst_o), LW'(wq.pop_front()));
      end
      if (resp_o) begin
        if (prev_resp) fail("resp_o_back_to_back");
        if (exp_q.size() == 0) fail("unexpected_resp");
        else begin
          mon_e = exp_q.pop_front();
          chk_int("burst_cycles", busy_cnt, mon_e.busy);
          chk("line_o_at_resp", line_o, mon_e.is_rd ? mon_e.line : model_line);
          if (mon_e.is_rd) model_line = mon_e.line;
        end
        busy_cnt = 0;
      end
      prev_resp = resp_o;
    end
  end

  // Drives one complete transaction from an IDLE cycle (called at posedge+1).
  task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wl, input logic [LW-1:0] rl,
                         input int stall_pct, input bit use_fixed);
    int   pat[$];
    int   ones;
    int   acks;
    exp_t e;
    ones = 0;
    acks = 0;
    if (use_fixed) pat = fixed_pat;
    else begin
      while (ones < NB) begin
        if (pat.size() < 12 && $urandom_range(99) < stall_pct) pat.push_back(0);
        else begin
          pat.push_back(1);
          ones++;
        end
      end
    end
    e.is_rd = rd && !wr;
    e.addr  = {addr[AW-1:5], 5'b0};
    e.line  = rl;
    e.busy  = pat.size();
    exp_q.push_back(e);
    if (!e.is_rd) for (int i = 0; i < NB; i++) wq.push_back(wl[i*BW +: BW]);
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = wl;
    resp_i    = 1'($urandom_range(1));
    @(posedge clk); #1;
    foreach (pat[i]) begin
      resp_i    = (pat[i] != 0);
      burst_i   = (pat[i] != 0) ? rl[acks*BW +: BW] : {$urandom, $urandom};
      read_i    = 1'($urandom_range(1));
      write_i   = 1'($urandom_range(1));
      address_i = $urandom;
      line_i    = rand_line();
      @(posedge clk); #1;
      if (pat[i] != 0) acks++;
    end
    // DONE cycle: request held and memory ack toggled, both must be ignored.
    resp_i  = 1'($urandom_range(1));
    read_i  = 1'b1;
    write_i = 1'($urandom_range(1));
    @(posedge clk); #1;
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'($urandom_range(1));
    chk_int("txn_completed", exp_q.size() + wq.size(), 0);
  endtask

  initial begin
    logic [LW-1:0] rl;
    rst       = 1'b1;
    line_i    = rand_line();
    address_i = $urandom;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_line_o", line_o, '0);
    chk("reset_address_o", LW'(address_o), '0);
    chk("reset_burst_o", LW'(burst_o), '0);
    chk("reset_resp_o", LW'(resp_o), '0);
    chk("reset_read_o", LW'(read_o), '0);
    chk("reset_write_o", LW'(write_o), '0);
    @(posedge clk); #1;

    // Read with no stalls, unaligned address.
    rl = {64'hDDDD_DDDD_DDDD_DDD3, 64'hCCCC_CCCC_CCCC_CCC2,
          64'hBBBB_BBBB_BBBB_BBB1, 64'hAAAA_AAAA_AAAA_AAA0};
    run_txn(1'b1, 1'b0, 32'h0000_1234, rand_line(), rl, 0, 1'b0);
    chk("read_addr_aligned", LW'(address_o), LW'(32'h0000_1220));

    // Write with fixed stall pattern 1,0,0,1,1,0,1.
    fixed_pat = '{1, 0, 0, 1, 1, 0, 1};
    run_txn(1'b0, 1'b1, 32'h0000_8F3C,
            256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF,
            rand_line(), 0, 1'b1);

    // Read and write together: write wins, line_o untouched.
    run_txn(1'b1, 1'b1, $urandom, rand_line(), rand_line(), 30, 1'b0);

    // Reset after the second read beat.
    rl = rand_line();
    begin
      exp_t e;
      e.is_rd = 1'b1;
      e.addr  = 32'h0004_0000;
      e.line  = rl;
      e.busy  = 0;
      exp_q.push_back(e);
    end
    read_i    = 1'b1;
    address_i = 32'h0004_001F;
    @(posedge clk); #1;
    read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_i  = 1'b1;
      burst_i = rl[i*BW +: BW];
      @(posedge clk); #1;
    end
    rst    = 1'b1;
    resp_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_read_o", LW'(read_o), '0);
    chk("abort_line_o", line_o, '0);
    chk("abort_resp_o", LW'(resp_o), '0);
    chk("abort_address_o", LW'(address_o), '0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_resp", LW'(resp_o), '0);
    end
    run_txn(1'b1, 1'b0, $urandom, rand_line(), rand_line(), 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = $urandom_range(2);
      run_txn(kind != 1, kind != 0, $urandom, rand_line(), rand_line(),
              $urandom_range(60), 1'b0);
      repeat ($urandom_range(2)) begin
        resp_i = 1'($urandom_range(1));
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
